// File: rtl/run_monitor_pkg.sv
// run_monitor_pkg: shared FSM state encoding and default parameter constants
// for the run_monitor block and its interface.
package run_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_DONE    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_e;

    localparam int unsigned DEF_NUM_CORES      = 1;
    localparam int unsigned DEF_CNT_W          = 32;
    localparam int unsigned DEF_DRAIN_CYCLES   = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 100000;
    localparam int unsigned DEF_HALT_ALL       = 1;

endpackage

// File: rtl/run_monitor_if.sv
// run_monitor_if: control/status bundle between a run controller (master)
// and the run monitor (slave).
//   start, clear          : run request / return-to-idle request
//   halt_in, retire_in    : per-core halt level and retire pulse
//   core_rstn             : active-low reset to the cores
//   exit, timed_out       : run finished / finished by watchdog
//   halted_mask           : sticky per-core halt record
//   cycle_count, retire_count : run statistics
interface run_monitor_if
    import run_monitor_pkg::*;
#(
    parameter int unsigned NUM_CORES = DEF_NUM_CORES,
    parameter int unsigned CNT_W     = DEF_CNT_W
) ();

    logic                 start;
    logic                 clear;
    logic [NUM_CORES-1:0] halt_in;
    logic [NUM_CORES-1:0] retire_in;
    logic                 core_rstn;
    logic                 exit;
    logic                 timed_out;
    logic [NUM_CORES-1:0] halted_mask;
    logic [CNT_W-1:0]     cycle_count;
    logic [CNT_W-1:0]     retire_count;

    modport master (
        output start, clear, halt_in, retire_in,
        input  core_rstn, exit, timed_out, halted_mask, cycle_count, retire_count
    );

    modport slave (
        input  start, clear, halt_in, retire_in,
        output core_rstn, exit, timed_out, halted_mask, cycle_count, retire_count
    );

endinterface

// File: rtl/run_monitor_popcount.sv
// popcount_n: number of set bits in a NUM_CORES-wide vector.
//   bits_i  : input vector
//   count_o : population count, $clog2(NUM_CORES+1) bits
module popcount_n #(
    parameter int unsigned NUM_CORES = 1
) (
    input  logic [NUM_CORES-1:0]         bits_i,
    output logic [$clog2(NUM_CORES+1)-1:0] count_o
);

    localparam int unsigned OW = $clog2(NUM_CORES + 1);

    always_comb begin
        count_o = '0;
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            count_o = count_o + OW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/run_monitor.sv
// run_monitor: sequences a test run of NUM_CORES cores. Releases core reset on
// start, waits for the halt condition (all or any core halted), allows a
// fixed pipeline-drain period, then reports exit. A watchdog ends the run
// with timed_out if the halt condition never arrives.
//   clk, rstn : system clock, asynchronous active-low reset
//   bus       : run_monitor_if slave modport (control in, status out)
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned NUM_CORES      = DEF_NUM_CORES,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned DRAIN_CYCLES   = DEF_DRAIN_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned HALT_ALL       = DEF_HALT_ALL
) (
    input  logic         clk,
    input  logic         rstn,
    run_monitor_if.slave bus
);

    localparam int unsigned PCW = $clog2(NUM_CORES + 1);
    localparam int unsigned SW  = CNT_W + 1;
    // Drain counter is loaded with DRAIN_CYCLES-1 and exits DRAIN at zero.
    localparam logic [7:0]  DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);
    // Compared at 64 bits so a narrow counter cannot alias a large limit.
    localparam logic [63:0] TO_LAST = 64'(TIMEOUT_CYCLES) - 64'd1;

    state_e               state_q, state_d;
    logic [NUM_CORES-1:0] mask_q, mask_d, halt_term;
    logic [CNT_W-1:0]     cycle_q, cycle_d, cycle_inc;
    logic [CNT_W-1:0]     retire_q, retire_d, retire_sat;
    logic [CNT_W:0]       retire_sum;
    logic [7:0]           drain_q, drain_d;
    logic [PCW-1:0]       retire_pop;
    logic                 halt_cond, to_hit;

    popcount_n #(.NUM_CORES(NUM_CORES)) u_pop (
        .bits_i  (bus.retire_in),
        .count_o (retire_pop)
    );

    always_comb begin
        halt_term  = mask_q | bus.halt_in;
        halt_cond  = (HALT_ALL != 0) ? (&halt_term) : (|halt_term);
        to_hit     = (TIMEOUT_CYCLES != 0) && (64'(cycle_q) == TO_LAST);
        cycle_inc  = (cycle_q == '1) ? cycle_q : cycle_q + CNT_W'(1);
        retire_sum = {1'b0, retire_q} + SW'(retire_pop);
        retire_sat = retire_sum[CNT_W] ? '1 : retire_sum[CNT_W-1:0];
    end

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        cycle_d  = cycle_q;
        retire_d = retire_q;
        drain_d  = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d  = ST_RUN;
                    mask_d   = '0;
                    cycle_d  = '0;
                    retire_d = '0;
                end
            end
            ST_RUN: begin
                cycle_d  = cycle_inc;
                retire_d = retire_sat;
                mask_d   = mask_q | bus.halt_in;
                // Halt takes priority over a coincident watchdog expiry.
                if (halt_cond) begin
                    if (DRAIN_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        drain_d = DRAIN_LOAD;
                    end
                end else if (to_hit) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                cycle_d  = cycle_inc;
                retire_d = retire_sat;
                if (drain_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = drain_q - 8'd1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (bus.clear) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            cycle_q  <= '0;
            retire_q <= '0;
            drain_q  <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            cycle_q  <= cycle_d;
            retire_q <= retire_d;
            drain_q  <= drain_d;
        end
    end

    assign bus.core_rstn    = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign bus.exit         = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    assign bus.timed_out    = (state_q == ST_TIMEOUT);
    assign bus.halted_mask  = mask_q;
    assign bus.cycle_count  = cycle_q;
    assign bus.retire_count = retire_q;

endmodule

// File: tb/tb_run_monitor.sv
// tb_run_monitor: three run_monitor configurations driven with directed and
// random halt/retire schedules; expected results are computed from the halt
// times and retire pattern of each run.
//   u0: 1 core,  32-bit counters, drain 4, watchdog 50, all-halt
//   u1: 2 cores,  8-bit counters, drain 4, no watchdog, all-halt
//   u2: 2 cores,  4-bit counters, drain 0, no watchdog, any-halt
module tb_run_monitor;

    localparam int P_NC [3] = '{1, 2, 2};
    localparam int P_W  [3] = '{32, 8, 4};
    localparam int P_D  [3] = '{4, 4, 0};
    localparam int P_TO [3] = '{50, 0, 0};
    localparam int P_HA [3] = '{1, 1, 0};
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic rstn;
    logic [2:0]       start_v, clear_v;
    logic [2:0][1:0]  halt_v, ret_v;
    logic [2:0]       ex_w, to_w, cr_w;
    logic [2:0][1:0]  mk_w;
    logic [2:0][31:0] cy_w, rt_w;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    run_monitor_if #(.NUM_CORES(1), .CNT_W(32)) bus0 ();
    run_monitor_if #(.NUM_CORES(2), .CNT_W(8))  bus1 ();
    run_monitor_if #(.NUM_CORES(2), .CNT_W(4))  bus2 ();

    run_monitor #(.NUM_CORES(1), .CNT_W(32), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(50), .HALT_ALL(1))
        u0 (.clk(clk), .rstn(rstn), .bus(bus0));
    run_monitor #(.NUM_CORES(2), .CNT_W(8), .DRAIN_CYCLES(4), .TIMEOUT_CYCLES(0), .HALT_ALL(1))
        u1 (.clk(clk), .rstn(rstn), .bus(bus1));
    run_monitor #(.NUM_CORES(2), .CNT_W(4), .DRAIN_CYCLES(0), .TIMEOUT_CYCLES(0), .HALT_ALL(0))
        u2 (.clk(clk), .rstn(rstn), .bus(bus2));

    assign bus0.start = start_v[0];  assign bus0.clear = clear_v[0];
    assign bus1.start = start_v[1];  assign bus1.clear = clear_v[1];
    assign bus2.start = start_v[2];  assign bus2.clear = clear_v[2];
    assign bus0.halt_in = halt_v[0][0:0];  assign bus0.retire_in = ret_v[0][0:0];
    assign bus1.halt_in = halt_v[1];       assign bus1.retire_in = ret_v[1];
    assign bus2.halt_in = halt_v[2];       assign bus2.retire_in = ret_v[2];

    assign ex_w = {bus2.exit, bus1.exit, bus0.exit};
    assign to_w = {bus2.timed_out, bus1.timed_out, bus0.timed_out};
    assign cr_w = {bus2.core_rstn, bus1.core_rstn, bus0.core_rstn};
    assign mk_w[0] = {1'b0, bus0.halted_mask};
    assign mk_w[1] = bus1.halted_mask;
    assign mk_w[2] = bus2.halted_mask;
    assign cy_w[0] = bus0.cycle_count;
    assign cy_w[1] = {24'd0, bus1.cycle_count};
    assign cy_w[2] = {28'd0, bus2.cycle_count};
    assign rt_w[0] = bus0.retire_count;
    assign rt_w[1] = {24'd0, bus1.retire_count};
    assign rt_w[2] = {28'd0, bus2.retire_count};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input int d, input string tag);
        check({tag, ".exit"}, 32'(ex_w[d]), 0);
        check({tag, ".core_rstn"}, 32'(cr_w[d]), 0);
        check({tag, ".timed_out"}, 32'(to_w[d]), 0);
        check({tag, ".mask"}, 32'(mk_w[d]), 0);
        check({tag, ".cycles"}, cy_w[d], 0);
        check({tag, ".retires"}, rt_w[d], 0);
    endtask

    // One complete run on DUT d: core0 halts from RUN cycle t0 onward, core1
    // from t1. The outcome is derived from the halt times alone.
    task automatic run_case(input int d, input int t0, input int t1, input bit ones, input string tag);
        logic [1:0] rp [0:127];
        int    nc, h, fin, last_run, exp_ret, exp_cyc;
        longint sat;
        bit    to_exp;
        logic [1:0] exp_mask;
        nc  = P_NC[d];
        sat = (longint'(1) << P_W[d]) - 1;
        if (nc == 1)          h = t0;
        else if (P_HA[d] != 0) h = (t0 > t1) ? t0 : t1;
        else                   h = (t0 < t1) ? t0 : t1;
        to_exp = (P_TO[d] != 0) && (h >= P_TO[d]);
        if (to_exp) begin
            fin = P_TO[d];
            last_run = fin - 1;
        end else begin
            fin = h + 1 + P_D[d];
            last_run = h;
        end
        exp_mask = {(nc == 2) && (t1 <= last_run), t0 <= last_run};
        exp_ret = 0;
        for (int k = 0; k < 128; k++) begin
            rp[k] = ones ? 2'b11 : 2'($urandom_range(0, 3));
            if (nc == 1) rp[k][1] = 1'b0;
            if (k < fin) exp_ret += int'(rp[k][0]) + int'(rp[k][1]);
        end
        if (exp_ret > sat) exp_ret = int'(sat);
        exp_cyc = (fin > sat) ? int'(sat) : fin;

        @(posedge clk); #1;
        halt_v[d] = '0; ret_v[d] = '0; start_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        check({tag, ".cycles@start"}, cy_w[d], 0);
        check({tag, ".retires@start"}, rt_w[d], 0);
        check({tag, ".mask@start"}, 32'(mk_w[d]), 0);
        for (int k = 0; k <= fin + 2; k++) begin
            check($sformatf("%s.exit@%0d", tag, k), 32'(ex_w[d]), 32'(k >= fin));
            check($sformatf("%s.core_rstn@%0d", tag, k), 32'(cr_w[d]), 32'(k < fin));
            check($sformatf("%s.timed_out@%0d", tag, k), 32'(to_w[d]), 32'((k >= fin) && to_exp));
            halt_v[d] = {(nc == 2) && (t1 <= k), t0 <= k};
            ret_v[d]  = rp[k];
            if (k == fin + 1) start_v[d] = 1'b1;
            @(posedge clk); #1;
            start_v[d] = 1'b0;
        end
        check({tag, ".cycles"}, cy_w[d], 32'(exp_cyc));
        check({tag, ".retires"}, rt_w[d], 32'(exp_ret));
        check({tag, ".mask"}, 32'(mk_w[d]), 32'(exp_mask));
        check({tag, ".exit_hold"}, 32'(ex_w[d]), 1);
        clear_v[d] = 1'b1;
        @(posedge clk); #1;
        clear_v[d] = 1'b0;
        halt_v[d] = '0; ret_v[d] = '0;
        check({tag, ".exit@clear"}, 32'(ex_w[d]), 0);
        check({tag, ".core_rstn@clear"}, 32'(cr_w[d]), 0);
        check({tag, ".cycles@clear"}, cy_w[d], 32'(exp_cyc));
        check({tag, ".retires@clear"}, rt_w[d], 32'(exp_ret));
    endtask

    initial begin
        rstn = 1'b0;
        start_v = '0; clear_v = '0; halt_v = '0; ret_v = '0;
        #12;
        for (int d = 0; d < 3; d++) check_idle_zero(d, $sformatf("reset%0d", d));
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) check_idle_zero(d, $sformatf("idle%0d", d));

        // Reset in the middle of DRAIN aborts the run.
        @(posedge clk); #1;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            halt_v[0] = {1'b0, k >= 3};
            @(posedge clk); #1;
        end
        check("drain.core_rstn", 32'(cr_w[0]), 1);
        check("drain.exit", 32'(ex_w[0]), 0);
        #2 rstn = 1'b0;
        #1 check_idle_zero(0, "midreset");
        repeat (2) @(posedge clk);
        #1 check("midreset.exit_hold", 32'(ex_w[0]), 0);
        rstn = 1'b1;
        halt_v[0] = '0;
        repeat (3) @(posedge clk);
        #1 check_idle_zero(0, "postreset");

        // Directed cases.
        run_case(0, 10, NEVER, 1'b0, "halt10");
        run_case(0, NEVER, NEVER, 1'b0, "timeout");
        run_case(0, 49, NEVER, 1'b0, "halt49");
        run_case(0, 48, NEVER, 1'b0, "halt48");
        run_case(0, 0, NEVER, 1'b0, "halt0");
        run_case(1, 5, 20, 1'b0, "all_5_20");
        run_case(2, 5, 20, 1'b0, "any_5_20");
        run_case(2, 6, NEVER, 1'b1, "ret7");
        run_case(2, 7, NEVER, 1'b1, "ret8sat");
        run_case(2, 20, 20, 1'b0, "cycsat");
        run_case(2, 0, 3, 1'b0, "any0");

        // Random halt schedules.
        for (int i = 0; i < 8; i++)
            run_case(0, int'($urandom_range(0, 70)), NEVER, 1'b0, $sformatf("rnd0_%0d", i));
        for (int i = 0; i < 6; i++)
            run_case(1, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0,
                     $sformatf("rnd1_%0d", i));
        for (int i = 0; i < 6; i++)
            run_case(2, int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 1'b0,
                     $sformatf("rnd2_%0d", i));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
